// File: rtl/bp_be_itag_tracker.sv
// In-order tracker of in-flight BE instructions: grants sequential itags at issue,
// retires the oldest on commit and squashes everything younger than a flush itag.
module bp_be_itag_tracker #(
    parameter int                        itag_width_p     = 8,
    parameter int                        els_p            = 5,
    parameter int                        vaddr_width_p    = 39,
    parameter logic [vaddr_width_p-1:0]  pc_entry_point_p = 'h80000124
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic                          alloc_v_i,
    input  logic [vaddr_width_p-1:0]      alloc_pc_i,
    output logic                          alloc_ready_o,
    output logic [itag_width_p-1:0]       alloc_itag_o,
    input  logic                          commit_v_i,
    input  logic [itag_width_p-1:0]       commit_itag_i,
    input  logic                          flush_v_i,
    input  logic [itag_width_p-1:0]       flush_itag_i,
    output logic                          oldest_v_o,
    output logic [itag_width_p-1:0]       oldest_itag_o,
    output logic [vaddr_width_p-1:0]      oldest_pc_o,
    output logic [$clog2(els_p+1)-1:0]    count_o,
    output logic                          err_o
);

    localparam int ptr_w = (els_p > 1) ? $clog2(els_p) : 1;
    localparam int cnt_w = $clog2(els_p + 1);
    localparam int sum_w = ((ptr_w > cnt_w) ? ptr_w : cnt_w) + 1;

    logic [vaddr_width_p-1:0] pc_mem [els_p];
    logic [ptr_w-1:0]         rd_ptr, wr_ptr, rd_ptr_n, wr_ptr_n, rd_ptr_c;
    logic [cnt_w-1:0]         count, count_n, count_c;
    logic [itag_width_p-1:0]  next_itag, next_itag_n;
    logic [itag_width_p-1:0]  oldest_c, flush_age;
    logic                     err, err_n;
    logic [vaddr_width_p-1:0] hold_pc;
    logic                     full, fire, pop, flush_hit, flush_popped;

    // Pointer advance modulo els_p; n never exceeds els_p so one subtract suffices.
    function automatic logic [ptr_w-1:0] wrap_add(input logic [ptr_w-1:0] p,
                                                  input logic [cnt_w-1:0] n);
        logic [sum_w-1:0] s;
        s = sum_w'(p) + sum_w'(n);
        if (s >= sum_w'(els_p))
            s = s - sum_w'(els_p);
        return s[ptr_w-1:0];
    endfunction

    // Itags are handed out consecutively, so the oldest one is implied by next_itag and count.
    assign full          = (count == cnt_w'(els_p));
    assign alloc_ready_o = ~full & ~flush_v_i & ~reset_i;
    assign fire          = alloc_v_i & alloc_ready_o;
    assign alloc_itag_o  = next_itag;
    assign oldest_v_o    = (count != '0);
    assign oldest_itag_o = next_itag - itag_width_p'(count);
    assign oldest_pc_o   = oldest_v_o ? pc_mem[rd_ptr] : hold_pc;
    assign count_o       = count;
    assign err_o         = err;

    always_comb begin
        pop          = commit_v_i & oldest_v_o & (commit_itag_i == oldest_itag_o);
        count_c      = count - cnt_w'(pop);
        oldest_c     = oldest_itag_o + itag_width_p'(pop);
        rd_ptr_c     = pop ? wrap_add(rd_ptr, cnt_w'(1)) : rd_ptr;
        flush_age    = flush_itag_i - oldest_c;
        flush_hit    = (flush_age < itag_width_p'(count_c));
        flush_popped = pop & (flush_itag_i == oldest_itag_o);

        rd_ptr_n    = rd_ptr_c;
        wr_ptr_n    = fire ? wrap_add(wr_ptr, cnt_w'(1)) : wr_ptr;
        count_n     = count_c + cnt_w'(fire);
        next_itag_n = fire ? next_itag + itag_width_p'(1) : next_itag;
        err_n       = err | (commit_v_i & ~pop);

        // Flush sees the post-commit tracker; alloc cannot fire alongside it.
        if (flush_v_i) begin
            if (flush_popped) begin
                count_n     = '0;
                wr_ptr_n    = rd_ptr_c;
                next_itag_n = flush_itag_i + itag_width_p'(1);
            end else if (flush_hit) begin
                count_n     = cnt_w'(flush_age) + cnt_w'(1);
                wr_ptr_n    = wrap_add(rd_ptr_c, count_n);
                next_itag_n = flush_itag_i + itag_width_p'(1);
            end else begin
                err_n = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            next_itag <= '0;
            err       <= 1'b0;
            hold_pc   <= pc_entry_point_p;
        end else begin
            rd_ptr    <= rd_ptr_n;
            wr_ptr    <= wr_ptr_n;
            count     <= count_n;
            next_itag <= next_itag_n;
            err       <= err_n;
            if (pop)
                hold_pc <= pc_mem[rd_ptr];
        end
    end

    always_ff @(posedge clk_i) begin
        if (fire)
            pc_mem[wr_ptr] <= alloc_pc_i;
    end

endmodule
